rng_draw_arbiter: RTL and testbench
===================================

# rng_draw_arbiter

Shares the free-running 16-bit LFSR random source between several game-logic requesters and delivers each one an unbiased draw in the range [0, LIMIT), e.g. the 4-digit secret for a new Numberle round. Round-robin arbitration, SAMPLE_GAP-cycle decorrelation spacing between LFSR samples, and rejection sampling with a bounded retry count. Sits between the RNG output and the game controller/display logic.

## Interface

**Parameters**
- NUM_REQ, 2: number of requesters, 1..8.
- LIMIT, 10000: exclusive upper bound of delivered values, 2..2^VAL_W.
- VAL_W, 14: candidate/value width, ≤16. 2^VAL_W ≥ LIMIT.
- SAMPLE_GAP, 16: cycles between successive LFSR samples, ≥1.
- MAX_TRIES, 8: rejected samples before fallback, ≥1.

**Ports**
- clock, in, 1: sole clock, rising edge.
- reset, in, 1: synchronous, active-high.
- rng_value, in, 16: current LFSR output.
- req, in, NUM_REQ: per-requester level request; held until matching gnt bit.
- gnt, out, NUM_REQ: one-hot, one-cycle pulse; draw result valid this cycle.
- value, out, VAL_W: drawn value; held until next gnt.
- fail, out, 1: qualifies gnt; 1 means retry limit hit and value is the fallback 0.
- busy, out, 1: high from acceptance through the gnt cycle.
- bcd, out, 16: four BCD digits of value. Present only with RNG_DRAW_BCD_EN.

## Operation

- FSM states: IDLE, WAIT, [CONV], DONE.
- **IDLE**
  - If req ≠ 0: pick the first set bit at or after rr_ptr, cyclically. Latch it as owner.
  - Load gap_cnt = SAMPLE_GAP-1 and tries = 0, then go to WAIT.
- **WAIT**
  - If gap_cnt ≠ 0: decrement gap_cnt.
  - If gap_cnt == 0: cand = rng_value[VAL_W-1:0].
    - cand < LIMIT: value ← cand, fail ← 0, go to DONE (CONV if BCD enabled).
    - Otherwise: tries++. If tries reaches MAX_TRIES: value ← 0, fail ← 1, go to DONE (CONV if enabled). Else reload gap_cnt = SAMPLE_GAP-1 and stay in WAIT.
- **DONE**
  - gnt[owner] = 1 for exactly one cycle.
  - rr_ptr ← owner+1, mod NUM_REQ.
  - Go to IDLE.
- Requests arriving while busy wait. They are never lost; req is level-sensitive.
- Dropping req mid-draw does not abort the draw. The draw completes and gnt still pulses.
- Comparison is unsigned, full VAL_W width. Upper rng_value bits above VAL_W are ignored.
- Reset state: IDLE; rr_ptr=0, gnt=0, value=0, fail=0, busy=0, bcd=0.
- Reset mid-draw: the next cycle is IDLE. No gnt is issued, and value/fail return to 0.

## Timing

- Acceptance in cycle t (IDLE with req≠0). busy is high from t+1.
- First sample is taken at t+SAMPLE_GAP. Sample k (k≥1) is taken at t+k·SAMPLE_GAP.
- gnt for accept on sample k: cycle t+k·SAMPLE_GAP+1 (no BCD).
- Fallback gnt: t+MAX_TRIES·SAMPLE_GAP+1.
- busy falls the cycle after gnt. A new acceptance is possible in that same cycle, so the minimum gnt-to-next-accept spacing is 1 cycle.
- With BCD enabled, CONV adds VAL_W cycles before DONE.

## Configuration

- RNG_DRAW_BCD_EN defined:
  - Adds the CONV state: a sequential double-dabble that shifts one bit per cycle for VAL_W cycles, with add-3 on digits ≥5.
  - bcd is updated together with value and is valid at gnt.
  - The fallback 0 also passes through CONV, giving bcd = 0x0000.
- Undefined: no bcd port, no CONV state, no conversion logic.

## Test plan

1. Hold reset for 3 cycles with req=2'b11 → gnt=0, busy=0, value=0, fail=0 throughout; IDLE after release.
2. req=2'b01, rng_value=16'h1234 held → gnt=2'b01 exactly 17 cycles after acceptance, value=4660, fail=0.
3. req=2'b10, rng_value=16'hFFFF (cand 16383, rejected) until the first sample, then 16'h0009 → gnt=2'b10 at acceptance+33, value=9.
4. rng_value=16'h3FFF held → 8 rejections, gnt at acceptance+129 with fail=1, value=0.
5. req=2'b11 held continuously, rng_value=16'h0005 → gnts alternate 01, 10, 01, each value=5, with gnts 18 cycles apart. Reset asserted in WAIT → no gnt, and the next grant restarts at requester 0.
6. With RNG_DRAW_BCD_EN, rng_value=16'h1234 → gnt at acceptance+31, value=4660, bcd=16'h4660. With rng_value=16'h270F, bcd=16'h9999.

Source files
------------

// File: rtl/rng_draw_arbiter.sv
// rng_draw_arbiter: shares one free-running 16-bit LFSR between NUM_REQ requesters.
// Each requester gets an unbiased draw in [0, LIMIT). Arbitration is round-robin,
// LFSR samples are spaced SAMPLE_GAP cycles apart, and rejection sampling falls back
// to 0 (with fail set) after MAX_TRIES rejections.
// Optional feature macro: RNG_DRAW_BCD_EN adds a bit-serial double-dabble stage
// (CONV state) and the bcd_o port.
module rng_draw_arbiter #(
    parameter int unsigned NUM_REQ    = 2,
    parameter int unsigned LIMIT      = 10000,
    parameter int unsigned VAL_W      = 14,
    parameter int unsigned SAMPLE_GAP = 16,
    parameter int unsigned MAX_TRIES  = 8
) (
    input  logic               clock_i,
    input  logic               reset_i,
    input  logic [15:0]        rng_value_i,
    input  logic [NUM_REQ-1:0] req_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [VAL_W-1:0]   value_o,
    output logic               fail_o,
`ifdef RNG_DRAW_BCD_EN
    output logic [15:0]        bcd_o,
`endif
    output logic               busy_o
);

    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned GAP_W = (SAMPLE_GAP > 1) ? $clog2(SAMPLE_GAP) : 1;
    localparam int unsigned TRY_W = $clog2(MAX_TRIES + 1);
    localparam int unsigned CMP_W = VAL_W + 1;
`ifdef RNG_DRAW_BCD_EN
    localparam int unsigned CNT_W = $clog2(VAL_W + 1);
`endif

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
`ifdef RNG_DRAW_BCD_EN
        ST_CONV = 2'd2,
`endif
        ST_DONE = 2'd3
    } state_t;

    // State reached once a draw has produced its value (accepted or fallback)
`ifdef RNG_DRAW_BCD_EN
    localparam state_t ST_FIN = ST_CONV;
`else
    localparam state_t ST_FIN = ST_DONE;
`endif

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic [TRY_W-1:0]   tries_q, tries_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [VAL_W-1:0]   value_q, value_d;
    logic               fail_q, fail_d;
    logic               busy_q, busy_d;

`ifdef RNG_DRAW_BCD_EN
    logic [VAL_W-1:0]   conv_bin_q, conv_bin_d;
    logic [15:0]        conv_bcd_q, conv_bcd_d;
    logic [CNT_W-1:0]   conv_cnt_q, conv_cnt_d;
    logic [15:0]        bcd_q, bcd_d;
    logic [15:0]        dd_adj;
    logic [15:0]        dd_shift;
`endif

    logic [VAL_W-1:0]   cand;
    logic               cand_ok;
    logic [NUM_REQ-1:0] req_rot;
    logic               pick_valid;
    logic [IDX_W-1:0]   pick_off;
    logic [IDX_W:0]     pick_sum;
    logic [IDX_W-1:0]   pick_idx;
    logic               unused_rng;

    // Only the low VAL_W bits of the LFSR form a candidate
    assign cand       = rng_value_i[VAL_W-1:0];
    assign cand_ok    = {1'b0, cand} < CMP_W'(LIMIT);
    assign unused_rng = ^rng_value_i;

    // Round-robin pick: first set request at or after rr_ptr, cyclically
    always_comb begin
        pick_valid = 1'b0;
        pick_off   = '0;
        req_rot    = NUM_REQ'({req_i, req_i} >> rr_ptr_q);
        for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                pick_valid = 1'b1;
                pick_off   = IDX_W'(i);
            end
        end
        pick_sum = {1'b0, rr_ptr_q} + {1'b0, pick_off};
        if (pick_sum >= (IDX_W + 1)'(NUM_REQ)) begin
            pick_sum = pick_sum - (IDX_W + 1)'(NUM_REQ);
        end
        pick_idx = pick_sum[IDX_W-1:0];
    end

`ifdef RNG_DRAW_BCD_EN
    // One double-dabble step: add 3 to every digit >= 5, then shift in the next binary bit
    always_comb begin
        dd_adj = conv_bcd_q;
        for (int d = 0; d < 4; d++) begin
            if (dd_adj[4*d +: 4] >= 4'd5) begin
                dd_adj[4*d +: 4] = dd_adj[4*d +: 4] + 4'd3;
            end
        end
        dd_shift = {dd_adj[14:0], conv_bin_q[VAL_W-1]};
    end
`endif

    // Next-state and registered-output logic
    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        owner_d  = owner_q;
        gap_d    = gap_q;
        tries_d  = tries_q;
        value_d  = value_q;
        fail_d   = fail_q;
`ifdef RNG_DRAW_BCD_EN
        conv_bin_d = conv_bin_q;
        conv_bcd_d = conv_bcd_q;
        conv_cnt_d = conv_cnt_q;
        bcd_d      = bcd_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    owner_d = pick_idx;
                    gap_d   = GAP_W'(SAMPLE_GAP - 1);
                    tries_d = '0;
                    state_d = ST_WAIT;
                end
            end

            ST_WAIT: begin
                if (gap_q != '0) begin
                    gap_d = gap_q - GAP_W'(1);
                end else if (cand_ok) begin
                    value_d = cand;
                    fail_d  = 1'b0;
                    state_d = ST_FIN;
`ifdef RNG_DRAW_BCD_EN
                    conv_bin_d = cand;
                    conv_bcd_d = '0;
                    conv_cnt_d = CNT_W'(VAL_W - 1);
`endif
                end else if (tries_q == TRY_W'(MAX_TRIES - 1)) begin
                    // Retry budget exhausted: deliver the fallback 0
                    tries_d = tries_q + TRY_W'(1);
                    value_d = '0;
                    fail_d  = 1'b1;
                    state_d = ST_FIN;
`ifdef RNG_DRAW_BCD_EN
                    conv_bin_d = '0;
                    conv_bcd_d = '0;
                    conv_cnt_d = CNT_W'(VAL_W - 1);
`endif
                end else begin
                    tries_d = tries_q + TRY_W'(1);
                    gap_d   = GAP_W'(SAMPLE_GAP - 1);
                end
            end

`ifdef RNG_DRAW_BCD_EN
            ST_CONV: begin
                conv_bcd_d = dd_shift;
                conv_bin_d = conv_bin_q << 1;
                if (conv_cnt_q == '0) begin
                    bcd_d   = dd_shift;
                    state_d = ST_DONE;
                end else begin
                    conv_cnt_d = conv_cnt_q - CNT_W'(1);
                end
            end
`endif

            ST_DONE: begin
                rr_ptr_d = (owner_q == IDX_W'(NUM_REQ - 1)) ? '0 : owner_q + IDX_W'(1);
                state_d  = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        gnt_d  = (state_d == ST_DONE) ? (NUM_REQ'(1) << owner_d) : '0;
        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q  <= ST_IDLE;
            rr_ptr_q <= '0;
            owner_q  <= '0;
            gap_q    <= '0;
            tries_q  <= '0;
            gnt_q    <= '0;
            value_q  <= '0;
            fail_q   <= 1'b0;
            busy_q   <= 1'b0;
`ifdef RNG_DRAW_BCD_EN
            conv_bin_q <= '0;
            conv_bcd_q <= '0;
            conv_cnt_q <= '0;
            bcd_q      <= '0;
`endif
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            owner_q  <= owner_d;
            gap_q    <= gap_d;
            tries_q  <= tries_d;
            gnt_q    <= gnt_d;
            value_q  <= value_d;
            fail_q   <= fail_d;
            busy_q   <= busy_d;
`ifdef RNG_DRAW_BCD_EN
            conv_bin_q <= conv_bin_d;
            conv_bcd_q <= conv_bcd_d;
            conv_cnt_q <= conv_cnt_d;
            bcd_q      <= bcd_d;
`endif
        end
    end

    assign gnt_o   = gnt_q;
    assign value_o = value_q;
    assign fail_o  = fail_q;
    assign busy_o  = busy_q;
`ifdef RNG_DRAW_BCD_EN
    assign bcd_o   = bcd_q;
`endif

endmodule

// File: tb/tb_rng_draw_arbiter.sv
// Directed bench for rng_draw_arbiter with default parameters (2 requesters,
// LIMIT 10000, 14-bit values, gap 16, 8 tries). Honours RNG_DRAW_BCD_EN.
module tb_rng_draw_arbiter;

`ifdef RNG_DRAW_BCD_EN
    localparam int CONV_LAT = 14;
`else
    localparam int CONV_LAT = 0;
`endif
    localparam int LAT = 17 + CONV_LAT;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] rng;
    logic [1:0]  req;
    logic [1:0]  gnt;
    logic [13:0] value;
    logic        fail;
    logic        busy;
`ifdef RNG_DRAW_BCD_EN
    logic [15:0] bcd;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    rng_draw_arbiter dut (
        .clock_i     (clk),
        .reset_i     (rst),
        .rng_value_i (rng),
        .req_i       (req),
        .gnt_o       (gnt),
        .value_o     (value),
        .fail_o      (fail),
`ifdef RNG_DRAW_BCD_EN
        .bcd_o       (bcd),
`endif
        .busy_o      (busy)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // One draw from an idle DUT; rng switches from rng_a to rng_b at cycle offset sw
    task automatic draw(input string tag, input logic [1:0] r, input logic [15:0] rng_a,
                        input logic [15:0] rng_b, input int sw, input logic [1:0] eg,
                        input logic [13:0] ev, input logic ef, input int lat,
                        input logic [15:0] eb);
        int n;
        int k;
        n   = 0;
        k   = 0;
        req = r;
        rng = rng_a;
        while (n == 0 && k < lat + CONV_LAT + 20) begin
            @(posedge clk);
            @(negedge clk);
            k++;
            if (k == 1) check({tag, ".busy1"}, 32'(busy), 32'd1);
            if (k == sw) rng = rng_b;
            if (gnt != 2'b00) n = k;
        end
        check({tag, ".lat"}, 32'(n), 32'(lat + CONV_LAT));
        check({tag, ".gnt"}, 32'(gnt), 32'(eg));
        check({tag, ".val"}, 32'(value), 32'(ev));
        check({tag, ".fail"}, 32'(fail), 32'(ef));
`ifdef RNG_DRAW_BCD_EN
        check({tag, ".bcd"}, 32'(bcd), 32'(eb));
`else
        if (eb == 16'hFFFF) $display("note: unexpected bcd tag");
`endif
        req = 2'b00;
        @(posedge clk);
        @(negedge clk);
        check({tag, ".busy0"}, 32'(busy), 32'd0);
        check({tag, ".gnt0"}, 32'(gnt), 32'd0);
    endtask

    // Watchdog so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          ev_n;
        int          ev_cyc [3];
        logic [1:0]  ev_gnt [3];
        logic [13:0] ev_val [3];
        int          n;

        rst = 1'b1;
        req = 2'b11;
        rng = 16'h1234;

        // Reset held for 3 cycles with both requests up
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst.gnt", 32'(gnt), 32'd0);
            check("rst.busy", 32'(busy), 32'd0);
            check("rst.val", 32'(value), 32'd0);
            check("rst.fail", 32'(fail), 32'd0);
`ifdef RNG_DRAW_BCD_EN
            check("rst.bcd", 32'(bcd), 32'd0);
`endif
        end
        rst = 1'b0;
        req = 2'b00;
        @(posedge clk);
        @(negedge clk);
        check("idle.busy", 32'(busy), 32'd0);

        // Basic, one-rejection, fallback and boundary draws
        draw("t2",    2'b01, 16'h1234, 16'h1234,  0, 2'b01, 14'd4660, 1'b0,  17, 16'h4660);
        draw("t3",    2'b10, 16'hFFFF, 16'h0009, 17, 2'b10, 14'd9,    1'b0,  33, 16'h0009);
        draw("t4",    2'b10, 16'h3FFF, 16'h3FFF,  0, 2'b10, 14'd0,    1'b1, 129, 16'h0000);
        draw("lim",   2'b01, 16'h2710, 16'h270F, 17, 2'b01, 14'd9999, 1'b0,  33, 16'h9999);
        draw("upper", 2'b10, 16'hC005, 16'hC005,  0, 2'b10, 14'd5,    1'b0,  17, 16'h0005);

        // Both requesters held: grants alternate starting at requester 0
        req  = 2'b11;
        rng  = 16'h0005;
        ev_n = 0;
        for (int i = 0; i < 3; i++) begin
            ev_cyc[i] = 0;
            ev_gnt[i] = 2'b00;
            ev_val[i] = 14'd0;
        end
        for (int k = 1; k <= 3 * LAT + 2; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (gnt != 2'b00 && ev_n < 3) begin
                ev_cyc[ev_n] = k;
                ev_gnt[ev_n] = gnt;
                ev_val[ev_n] = value;
                ev_n++;
            end
        end
        check("rr.count", 32'(ev_n), 32'd3);
        check("rr.cyc0", 32'(ev_cyc[0]), 32'(LAT));
        check("rr.cyc1", 32'(ev_cyc[1]), 32'(2 * LAT + 1));
        check("rr.cyc2", 32'(ev_cyc[2]), 32'(3 * LAT + 2));
        check("rr.gnt0", 32'(ev_gnt[0]), 32'd1);
        check("rr.gnt1", 32'(ev_gnt[1]), 32'd2);
        check("rr.gnt2", 32'(ev_gnt[2]), 32'd1);
        check("rr.val0", 32'(ev_val[0]), 32'd5);
        check("rr.val1", 32'(ev_val[1]), 32'd5);
        check("rr.val2", 32'(ev_val[2]), 32'd5);

        // Requester 1 now owns a draw in WAIT; reset it mid-flight
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            @(negedge clk);
        end
        check("mid.busy", 32'(busy), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("mrst.gnt", 32'(gnt), 32'd0);
        check("mrst.busy", 32'(busy), 32'd0);
        check("mrst.val", 32'(value), 32'd0);
        check("mrst.fail", 32'(fail), 32'd0);
        rst = 1'b0;

        // After reset the pointer is back at requester 0
        n = 0;
        for (int k = 1; k <= LAT + 5 && n == 0; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (gnt != 2'b00) n = k;
        end
        check("post.lat", 32'(n), 32'(LAT));
        check("post.gnt", 32'(gnt), 32'd1);
        check("post.val", 32'(value), 32'd5);
        req = 2'b00;
        @(posedge clk);
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
